// File: rtl/uart_pkg.sv
// Shared UART TX definitions: FSM state encoding, parity types and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic IDLE_LVL = 1'b1;

    // data_xor is the XOR reduction of the payload; odd parity inverts it.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        logic p;
        case (par_typ)
            PAR_EVEN: p = data_xor;
            PAR_ODD:  p = ~data_xor;
            default:  p = data_xor;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit timer, period CLKS_PER_BIT; clr restarts the count at a byte load.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr || (cnt_reg == CNT_MAX)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    // Because clr lands the count at 0 in the load cycle, tick falls in the
    // second-to-last cycle of every bit, giving the FSM one cycle of look-ahead.
    assign tick = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops a byte when idle/at stop end and sends start, data, parity, stop.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_inc,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    uart_state_t           state_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  par_reg;
    logic                  par_en_reg;
    logic                  loading_reg;
    logic                  last_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  rd_inc_reg;
    logic                  tick;
    logic                  load_go;

    // Decided one cycle ahead so the pop strobe is registered yet coincides with
    // the load cycle (an idle cycle, or the final stop cycle for back-to-back frames).
    assign load_go = en && !fifo_empty &&
                     (((state_reg == ST_IDLE) && !loading_reg) ||
                      ((state_reg == ST_STOP) && tick));

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (load_go),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            idx_reg     <= '0;
            par_reg     <= 1'b0;
            par_en_reg  <= 1'b0;
            loading_reg <= 1'b0;
            last_reg    <= 1'b0;
            tx_reg      <= IDLE_LVL;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rd_inc_reg  <= 1'b0;
        end else begin
            rd_inc_reg  <= load_go;
            loading_reg <= load_go;
            last_reg    <= tick;
            done_reg    <= (state_reg == ST_STOP) && tick;

            if (load_go) begin
                shift_reg  <= fifo_rd_data;
                par_en_reg <= par_en;
                par_reg    <= parity_bit(^fifo_rd_data, par_typ);
                busy_reg   <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (loading_reg) begin
                        state_reg <= ST_START;
                        tx_reg    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (last_reg) begin
                        state_reg <= ST_DATA;
                        tx_reg    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        idx_reg   <= '0;
                    end
                end
                ST_DATA: begin
                    if (last_reg) begin
                        if (idx_reg == IDX_LAST) begin
                            idx_reg <= '0;
                            if (par_en_reg) begin
                                state_reg <= ST_PARITY;
                                tx_reg    <= par_reg;
                            end else begin
                                state_reg <= ST_STOP;
                                tx_reg    <= IDLE_LVL;
                            end
                        end else begin
                            idx_reg   <= idx_reg + IDX_W'(1);
                            tx_reg    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (last_reg) begin
                        state_reg <= ST_STOP;
                        tx_reg    <= IDLE_LVL;
                    end
                end
                ST_STOP: begin
                    if (last_reg) begin
                        if (loading_reg) begin
                            state_reg <= ST_START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= IDLE_LVL;
                end
            endcase
        end
    end

    assign fifo_rd_inc = rd_inc_reg;
    assign tx_out      = tx_reg;
    assign busy        = busy_reg;
    assign frame_done  = done_reg;

endmodule
